// File: rtl/mean_arbiter.sv
// mean_arbiter: round-robin front end sharing one frame-mean engine between two sample streams
module mean_arbiter #(
  parameter int DATA_W   = 16,
  parameter int LOG2_LEN = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s0_tvalid,
  output logic              s0_tready,
  input  logic [DATA_W-1:0] s0_tdata,
  input  logic              s1_tvalid,
  output logic              s1_tready,
  input  logic [DATA_W-1:0] s1_tdata,
  output logic              eng_tvalid,
  input  logic              eng_tready,
  output logic [DATA_W-1:0] eng_tdata,
  input  logic              res_tvalid,
  output logic              res_tready,
  input  logic [DATA_W-1:0] res_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tid,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, STREAM, WAIT_RES, OUTPUT} state_t;
  state_t              state_q, state_d;
  logic                gnt_q, gnt_d, last_q, last_d, m_tvalid_q, m_tvalid_d, m_tid_q, m_tid_d;
  logic [LOG2_LEN-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]   m_tdata_q, m_tdata_d;
  logic                pick, eng_hs;
  // on a tie the requester that did not win last time goes next
  assign pick       = (s0_tvalid && s1_tvalid) ? ~last_q : s1_tvalid;
  assign eng_tvalid = (state_q == STREAM) && (gnt_q ? s1_tvalid : s0_tvalid);
  assign eng_tdata  = gnt_q ? s1_tdata : s0_tdata;
  assign s0_tready  = (state_q == STREAM) && !gnt_q && eng_tready;
  assign s1_tready  = (state_q == STREAM) && gnt_q && eng_tready;
  assign eng_hs     = eng_tvalid && eng_tready;
  assign res_tready = state_q == WAIT_RES;
  assign m_tvalid   = m_tvalid_q;
  assign m_tdata    = m_tdata_q;
  assign m_tid      = m_tid_q;
  assign busy       = state_q != IDLE;
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tid_d    = m_tid_q;
    case (state_q)
      IDLE: if (s0_tvalid || s1_tvalid) begin
        state_d = STREAM;
        gnt_d   = pick;
        last_d  = pick;
        cnt_d   = '0;
      end
      STREAM: if (eng_hs) begin
        cnt_d   = cnt_q + LOG2_LEN'(1);
        state_d = &cnt_q ? WAIT_RES : STREAM;
      end
      WAIT_RES: if (res_tvalid) begin
        state_d    = OUTPUT;
        m_tvalid_d = 1'b1;
        m_tdata_d  = res_tdata;
        m_tid_d    = gnt_q;
      end
      OUTPUT: if (m_tready) begin
        state_d    = IDLE;
        m_tvalid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tid_q    <= m_tid_d;
    end
  end
endmodule
